gcd_engine: RTL and testbench

GCD_ENGINE -- requirements
Module: gcd_engine

---
 rtl/gcd_engine.sv | 83 ++++++++
 tb/tb_gcd_engine.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/gcd_engine.sv
// gcd_engine: iterative GCD core, one step per clock, using either subtractive Euclid or binary (Stein).
module gcd_engine #(
  parameter int WIDTH = 8,
  parameter int CW = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             err,
  output logic [CW-1:0]    cycles
);
  localparam int KW = $clog2(WIDTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a, b, a_n, b_n, res;
  logic [KW-1:0] k, k_n;
  logic [CW-1:0] cnt, cnt_inc;
  logic m, fin, commit;
  assign ready = state == IDLE;
  always_comb begin
    state_n = state;
    a_n = a;
    b_n = b;
    k_n = k;
    cnt_inc = &cnt ? cnt : cnt + CW'(1);
    fin = a == '0 || b == '0 || a == b;
    commit = state == RUN && fin;
    res = a == '0 ? b << k : a << k;
    if (state == IDLE) begin
      if (start) begin
        state_n = RUN;
        a_n = ina;
        b_n = inb;
        k_n = '0;
      end
    end else if (fin) state_n = IDLE;
    else if (!m) begin
      a_n = a < b ? b : a - b;
      b_n = a < b ? a : b;
    end else if (!a[0] && !b[0]) begin
      // common factors of two are stripped here and restored on commit
      a_n = a >> 1;
      b_n = b >> 1;
      k_n = k + KW'(1);
    end else if (!a[0]) a_n = a >> 1;
    else if (!b[0]) b_n = b >> 1;
    else if (a > b) a_n = (a - b) >> 1;
    else b_n = (b - a) >> 1;
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= IDLE;
      a      <= '0;
      b      <= '0;
      k      <= '0;
      m      <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
      out    <= '0;
      err    <= 1'b0;
      cycles <= '0;
    end else begin
      state <= state_n;
      a     <= a_n;
      b     <= b_n;
      k     <= k_n;
      m     <= (state == IDLE && start) ? mode : m;
      cnt   <= state == IDLE ? '0 : cnt_inc;
      done  <= commit;
      if (commit) begin
        out    <= res;
        err    <= a == '0 && b == '0;
        cycles <= cnt_inc;
      end
    end
  end
endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: directed vectors with hand-computed GCD results, cycle counts and handshake timing.
module tb_gcd_engine;
  logic clk = 0, nrst = 0, start = 0, mode = 0;
  logic [7:0] ina = 0, inb = 0;
  logic ready, done, err;
  logic [7:0] out;
  logic [15:0] cycles;
  int errors = 0, checks = 0;

  gcd_engine dut (.clk(clk), .nrst(nrst), .start(start), .mode(mode), .ina(ina), .inb(inb),
                  .ready(ready), .done(done), .out(out), .err(err), .cycles(cycles));

  always #5 clk = ~clk;

  // issues one request, then counts edges until ready returns and done pulses seen (including one idle cycle after)
  task automatic do_op(input logic m, input logic [7:0] x, input logic [7:0] y, input bit noise,
                       output int lat, output int dones);
    @(negedge clk);
    start = 1; mode = m; ina = x; inb = y;
    @(negedge clk);
    start = 0; lat = 0; dones = 0;
    while (!ready && lat < 1000) begin
      @(negedge clk);
      lat++;
      if (done) dones++;
      if (noise && !ready) begin
        start = 1'($urandom); mode = 1'($urandom); ina = 8'($urandom); inb = 8'($urandom);
      end else start = 0;
    end
    @(negedge clk);
    if (done) dones++;
  endtask

  task automatic test_reset;
    int lat, dn;
    #3;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (out !== 8'd0) begin errors++; $display("FAIL reset_out got=%0d exp=0", out); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (cycles !== 16'd0) begin errors++; $display("FAIL reset_cycles got=%0d exp=0", cycles); end
    @(negedge clk);
    nrst = 1;
    // first request right after reset release must be accepted on the first edge
    do_op(1'b0, 8'd9, 8'd6, 1'b0, lat, dn);
    checks++; if (out !== 8'd3) begin errors++; $display("FAIL first_start_out got=%0d exp=3", out); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL first_start_lat got=%0d exp=4", lat); end
  endtask

  task automatic test_euclid;
    int lat, dn;
    do_op(1'b0, 8'd12, 8'd8, 1'b0, lat, dn);
    checks++; if (out !== 8'd4) begin errors++; $display("FAIL euclid_out got=%0d exp=4", out); end
    checks++; if (cycles !== 16'd4) begin errors++; $display("FAIL euclid_cycles got=%0d exp=4", cycles); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL euclid_err got=%b exp=0", err); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL euclid_lat got=%0d exp=4", lat); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL euclid_done_pulses got=%0d exp=1", dn); end
  endtask

  task automatic test_stein;
    int lat, dn;
    do_op(1'b1, 8'd12, 8'd8, 1'b0, lat, dn);
    checks++; if (out !== 8'd4) begin errors++; $display("FAIL stein12_out got=%0d exp=4", out); end
    checks++; if (cycles !== 16'd5) begin errors++; $display("FAIL stein12_cycles got=%0d exp=5", cycles); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL stein12_lat got=%0d exp=5", lat); end
    do_op(1'b1, 8'd255, 8'd1, 1'b0, lat, dn);
    checks++; if (out !== 8'd1) begin errors++; $display("FAIL stein255_out got=%0d exp=1", out); end
    checks++; if (cycles !== 16'd8) begin errors++; $display("FAIL stein255_cycles got=%0d exp=8", cycles); end
    do_op(1'b1, 8'd6, 8'd4, 1'b0, lat, dn);
    checks++; if (out !== 8'd2) begin errors++; $display("FAIL stein64_out got=%0d exp=2", out); end
    checks++; if (cycles !== 16'd4) begin errors++; $display("FAIL stein64_cycles got=%0d exp=4", cycles); end
  endtask

  task automatic test_zero;
    int lat, dn;
    do_op(1'b0, 8'd0, 8'd9, 1'b0, lat, dn);
    checks++; if (out !== 8'd9) begin errors++; $display("FAIL zero_a_out got=%0d exp=9", out); end
    checks++; if (cycles !== 16'd1) begin errors++; $display("FAIL zero_a_cycles got=%0d exp=1", cycles); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL zero_a_err got=%b exp=0", err); end
    do_op(1'b1, 8'd0, 8'd0, 1'b0, lat, dn);
    checks++; if (out !== 8'd0) begin errors++; $display("FAIL zero_both_out got=%0d exp=0", out); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL zero_both_err got=%b exp=1", err); end
    checks++; if (cycles !== 16'd1) begin errors++; $display("FAIL zero_both_cycles got=%0d exp=1", cycles); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL zero_both_done got=%0d exp=1", dn); end
    do_op(1'b0, 8'd6, 8'd4, 1'b0, lat, dn);
    checks++; if (out !== 8'd2) begin errors++; $display("FAIL after_zero_out got=%0d exp=2", out); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL after_zero_err got=%b exp=0", err); end
    checks++; if (cycles !== 16'd4) begin errors++; $display("FAIL after_zero_cycles got=%0d exp=4", cycles); end
  endtask

  task automatic test_long_run;
    int lat, dn;
    // random start pulses and operand changes while busy must not disturb the result
    do_op(1'b0, 8'd255, 8'd1, 1'b1, lat, dn);
    checks++; if (out !== 8'd1) begin errors++; $display("FAIL long_out got=%0d exp=1", out); end
    checks++; if (cycles !== 16'd255) begin errors++; $display("FAIL long_cycles got=%0d exp=255", cycles); end
    checks++; if (lat !== 255) begin errors++; $display("FAIL long_lat got=%0d exp=255", lat); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL long_done got=%0d exp=1", dn); end
  endtask

  task automatic test_reset_mid_run;
    int lat, dn;
    dn = 0;
    @(negedge clk);
    start = 1; mode = 0; ina = 8'd200; inb = 8'd3;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", ready); end
    checks++; if (out !== 8'd1) begin errors++; $display("FAIL mid_hold_out got=%0d exp=1", out); end
    checks++; if (cycles !== 16'd255) begin errors++; $display("FAIL mid_hold_cycles got=%0d exp=255", cycles); end
    #2 nrst = 0;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", ready); end
    checks++; if (out !== 8'd0) begin errors++; $display("FAIL abort_out got=%0d exp=0", out); end
    checks++; if (cycles !== 16'd0) begin errors++; $display("FAIL abort_cycles got=%0d exp=0", cycles); end
    repeat (2) begin
      @(negedge clk);
      if (done) dn++;
    end
    nrst = 1;
    @(negedge clk);
    if (done) dn++;
    checks++; if (dn !== 0) begin errors++; $display("FAIL abort_done got=%0d exp=0", dn); end
    checks++; if (out !== 8'd0) begin errors++; $display("FAIL abort_out_held got=%0d exp=0", out); end
    do_op(1'b0, 8'd9, 8'd6, 1'b0, lat, dn);
    checks++; if (out !== 8'd3) begin errors++; $display("FAIL post_abort_out got=%0d exp=3", out); end
    checks++; if (cycles !== 16'd4) begin errors++; $display("FAIL post_abort_cycles got=%0d exp=4", cycles); end
  endtask

  initial begin
    test_reset;
    test_euclid;
    test_stein;
    test_zero;
    test_long_run;
    test_reset_mid_run;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
